// File: rtl/absorb_stream.sv
// Runtime-length absorb controller: one F run per message block,
// 10* byte padding and domain separation on the final block.
module absorb_stream #(
  parameter int CWIDTH      = 320,
  parameter int RWIDTH      = 192,
  parameter int XWIDTH      = 128,
  parameter int IWIDTH      = 128,
  parameter int MAXBLOCKS   = 16,
  parameter int ROUND_COUNT = 4,
  localparam int NBW = $clog2(MAXBLOCKS + 1),
  localparam int LBW = $clog2(IWIDTH / 8 + 1)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [CWIDTH-1:0]      c_i,
  input  logic [RWIDTH-1:0]      r_i,
  input  logic [XWIDTH-1:0]      x_i,
  input  logic [1:0]             domain_i,
  input  logic                   finalize_i,
  input  logic [ROUND_COUNT-1:0] rounds_i,
  input  logic [NBW-1:0]         nblocks_i,
  input  logic [LBW-1:0]         last_bytes_i,
  input  logic [IWIDTH-1:0]      blk_data_i,
  input  logic                   blk_valid_i,
  output logic                   blk_ready_o,
  output logic                   f_start_o,
  output logic [CWIDTH-1:0]      f_c_o,
  output logic [RWIDTH-1:0]      f_r_o,
  output logic [XWIDTH-1:0]      f_x_o,
  output logic [IWIDTH-1:0]      f_i_o,
  output logic [3:0]             f_ds_o,
  output logic [ROUND_COUNT-1:0] f_rounds_o,
  input  logic [CWIDTH-1:0]      f_cout_i,
  input  logic [RWIDTH-1:0]      f_rout_i,
  input  logic [XWIDTH-1:0]      f_xout_i,
  input  logic                   f_done_i,
  output logic [CWIDTH-1:0]      cout_o,
  output logic [RWIDTH-1:0]      rout_o,
  output logic [XWIDTH-1:0]      xout_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int NB = IWIDTH / 8;
  localparam logic [NBW-1:0] MAXB = NBW'(MAXBLOCKS);
  localparam logic [LBW-1:0] FULL = LBW'(NB);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_GET, S_RUN, S_WAIT, S_OUT
  } state_t;

  state_t                 state_q, state_d;
  logic [CWIDTH-1:0]      c_q, c_d;
  logic [RWIDTH-1:0]      r_q, r_d;
  logic [XWIDTH-1:0]      x_q, x_d;
  logic [IWIDTH-1:0]      blk_q, blk_d;
  logic [3:0]             ds_q, ds_d;
  logic [1:0]             dom_q, dom_d;
  logic                   fin_q, fin_d;
  logic [ROUND_COUNT-1:0] rnd_q, rnd_d;
  logic [NBW-1:0]         nblk_q, nblk_d;
  logic [NBW-1:0]         cnt_q, cnt_d;
  logic [LBW-1:0]         lb_q, lb_d;
  logic                   err_q, err_d;

  logic              last;
  logic              pad_en;
  logic [IWIDTH-1:0] pad_blk;

  assign last   = (cnt_q == NBW'(1));
  assign pad_en = last && (lb_q < FULL);

  // Final partial block: keep valid bytes, 0x01 marker, zero fill.
  always_comb begin
    pad_blk = blk_data_i;
    if (pad_en) begin
      for (int k = 0; k < NB; k++) begin
        if (k == int'(lb_q)) pad_blk[8*k +: 8] = 8'h01;
        else if (k > int'(lb_q)) pad_blk[8*k +: 8] = 8'h00;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    r_d     = r_q;
    x_d     = x_q;
    blk_d   = blk_q;
    ds_d    = ds_q;
    dom_d   = dom_q;
    fin_d   = fin_q;
    rnd_d   = rnd_q;
    nblk_d  = nblk_q;
    cnt_d   = cnt_q;
    lb_d    = lb_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if ((nblocks_i > MAXB) || (last_bytes_i > FULL)) begin
            err_d = 1'b1;
          end else begin
            c_d     = c_i;
            r_d     = r_i;
            x_d     = x_i;
            dom_d   = domain_i;
            fin_d   = finalize_i;
            rnd_d   = rounds_i;
            nblk_d  = nblocks_i;
            lb_d    = last_bytes_i;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (nblk_q == '0) begin
          cnt_d   = NBW'(1);
          blk_d   = IWIDTH'(1);
          ds_d    = {dom_q, fin_q, 1'b1};
          state_d = S_RUN;
        end else begin
          cnt_d   = nblk_q;
          state_d = S_GET;
        end
      end
      S_GET: begin
        if (blk_valid_i) begin
          blk_d   = pad_blk;
          ds_d    = last ? {dom_q, fin_q, pad_en} : 4'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: state_d = S_WAIT;
      S_WAIT: begin
        if (f_done_i) begin
          c_d     = f_cout_i;
          r_d     = f_rout_i;
          x_d     = f_xout_i;
          cnt_d   = cnt_q - NBW'(1);
          state_d = last ? S_OUT : S_GET;
        end
      end
      S_OUT: begin
        if (out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      c_q     <= '0;
      r_q     <= '0;
      x_q     <= '0;
      blk_q   <= '0;
      ds_q    <= '0;
      dom_q   <= '0;
      fin_q   <= 1'b0;
      rnd_q   <= '0;
      nblk_q  <= '0;
      cnt_q   <= '0;
      lb_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      r_q     <= r_d;
      x_q     <= x_d;
      blk_q   <= blk_d;
      ds_q    <= ds_d;
      dom_q   <= dom_d;
      fin_q   <= fin_d;
      rnd_q   <= rnd_d;
      nblk_q  <= nblk_d;
      cnt_q   <= cnt_d;
      lb_q    <= lb_d;
      err_q   <= err_d;
    end
  end

  assign blk_ready_o = (state_q == S_GET);
  assign f_start_o   = (state_q == S_RUN);
  assign out_valid_o = (state_q == S_OUT);
  assign busy_o      = (state_q != S_IDLE);
  assign err_o       = err_q;
  assign f_c_o       = c_q;
  assign f_r_o       = r_q;
  assign f_x_o       = x_q;
  assign f_i_o       = blk_q;
  assign f_ds_o      = ds_q;
  assign f_rounds_o  = rnd_q;
  assign cout_o      = out_valid_o ? c_q : '0;
  assign rout_o      = out_valid_o ? r_q : '0;
  assign xout_o      = out_valid_o ? x_q : '0;

endmodule
